imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter WIDTH, 32, instruction word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter N, 6, log2 of instruction memory depth in words; SHALL match the target memory's N.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 reset_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse that begins a load session.
REQ-006 byte_valid  input  1  byte_data is valid this cycle.
REQ-007 byte_data  input  8  next program byte; big-endian, first byte goes to wd[WIDTH-1:WIDTH-8].
REQ-008 byte_last  input  1  qualifies byte_valid; marks the final byte of the image.
REQ-009 byte_ready  output  1  loader accepts a byte this cycle.
REQ-010 we  output  1  memory write strobe, one cycle per word.
REQ-011 waddr  output  WIDTH  byte address of the word being written; bits [1:0] SHALL always be 0.
REQ-012 wd  output  WIDTH  write data.
REQ-013 busy  output  1  session in progress; also drives the CPU hold.
REQ-014 done  output  1  sticky until next start: image fully written.
REQ-015 overflow  output  1  sticky until next start: bytes arrived after 2**N words were written.

Function
REQ-016 States SHALL be IDLE, COLLECT, WRITE, DONE.
REQ-017 IDLE: byte_ready=0, we=0; start moves to COLLECT, clears done, overflow, word counter and byte counter.
REQ-018 COLLECT: byte_ready=1; each byte_valid SHALL shift byte_data into the word shifter and increment the byte counter modulo WIDTH/8.
REQ-019 The 4th byte, for WIDTH=32, or any byte with byte_last SHALL move to WRITE on the next edge.
REQ-020 On a byte_last that is not word-aligned, the unfilled low-order bytes of wd SHALL be zero.
REQ-021 WRITE: byte_ready=0 and we=1 for exactly one cycle, with waddr = word_count*4 and the assembled wd.
REQ-022 After WRITE, word_count SHALL increment; the next state SHALL be DONE if the last byte was seen, else COLLECT.
REQ-023 Latency: we SHALL assert exactly one cycle after the edge accepting the completing byte.
REQ-024 When word_count reaches 2**N, the loader SHALL stay in COLLECT with we suppressed, discard further bytes, and set overflow on the first discarded byte.
REQ-025 At that point it SHALL still reach DONE when byte_last arrives; waddr SHALL never wrap to 0.
REQ-026 DONE: done=1, busy=0; start re-enters COLLECT as in REQ-017.
REQ-027 start while busy=1 SHALL be ignored.
REQ-028 busy SHALL be 1 in COLLECT and WRITE, 0 otherwise.
REQ-029 byte_valid while byte_ready=0 SHALL be ignored; the source SHALL hold the byte until byte_ready.

Reset
REQ-030 reset_n low SHALL asynchronously force IDLE, with we=0, waddr=0, wd=0, busy=0, done=0, overflow=0, and both counters 0.
REQ-031 Reset mid-session SHALL abandon the partial word with no write; already-written words are not undone.

Configuration
REQ-032 With IMEM_LOADER_CHECKSUM_EN defined, output checksum [WIDTH-1:0] SHALL exist.
REQ-033 checksum SHALL be the XOR of every wd written in the session, cleared by start and by reset, and valid when done=1.
REQ-034 Without IMEM_LOADER_CHECKSUM_EN, the checksum port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-035 Shared package imem_pkg SHALL hold the state encoding (IDLE=0, COLLECT=1, WRITE=2, DONE=3), BYTES_PER_WORD=WIDTH/8, and the address alignment shift of 2.
REQ-036 One sub-module imem_word_packer SHALL contain the byte shifter, the byte counter and the zero-pad logic.
REQ-037 The FSM, address counter and flags SHALL stay in imem_loader.

Verification
REQ-038 Start, then bytes 20 08 00 05 8C 09 00 04 with last on the 8th byte -> writes (0x0, 0x20080005) then (0x4, 0x8C090004); done=1; busy=0.
REQ-039 Start, then bytes AA BB with last on the 2nd byte -> one write (0x0, 0xAABB0000); done=1.
REQ-040 N=2, 17 bytes with last on the 17th -> 4 writes at 0x0 to 0xC, none at 0x10; overflow=1; done=1.
REQ-041 Reset_n pulsed low after 3 of 4 bytes -> no we; all outputs 0; then a new start loads again from waddr 0.
REQ-042 start pulsed in COLLECT, and byte_valid held across WRITE -> no restart and no byte lost or duplicated.
REQ-043 With IMEM_LOADER_CHECKSUM_EN, the image of REQ-038 -> checksum=0xAC010001 at done.

Source files
------------

// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_pkg
// Purpose  : Shared definitions for the instruction-memory loader: FSM state
//            encoding, word geometry and the byte-address alignment shift.
// Revision : 1.0 - initial release
// ============================================================================
package imem_pkg;

    // Loader states, encoded explicitly so the encoding is visible in dumps.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Nominal instruction word width and the bytes that make up one word.
    localparam int WORD_WIDTH     = 32;
    localparam int BYTES_PER_WORD = WORD_WIDTH / 8;

    // Word index to byte address: waddr = word_count << ADDR_SHIFT.
    localparam int ADDR_SHIFT     = 2;

    // Bytes per word for an arbitrary (byte-multiple) word width.
    function automatic int bytes_per_word(input int width);
        return width / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : imem_word_packer
// Purpose  : Big-endian byte-to-word assembler. Shifts accepted bytes into a
//            word register, counts bytes within the word, and left-justifies
//            a short final word so its unfilled low-order bytes are zero.
// Revision : 1.0 - initial release
// ============================================================================
module imem_word_packer
    import imem_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             byte_last,
    input  logic [7:0]       byte_data,
    output logic             word_complete,
    output logic [WIDTH-1:0] word
);

    localparam int BPW = bytes_per_word(WIDTH);
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CW-1:0] c_last_idx = CW'(BPW - 1);

    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_padded;

    // New byte always enters at the bottom; earlier bytes move toward the MSB.
    if (WIDTH == 8) begin : g_shift_byte
        assign w_shifted = byte_data;
    end else begin : g_shift_wide
        assign w_shifted = {r_shift[WIDTH-9:0], byte_data};
    end

    // A word is complete on its final byte slot or on the image's last byte.
    assign word_complete = shift_en && (byte_last || (r_count == c_last_idx));

    // A short final word is moved up so the first byte lands in the MSBs.
    always_comb begin
        w_padded = w_shifted;
        if (byte_last) begin
            w_padded = w_shifted << {(c_last_idx - r_count), 3'b000};
        end
    end

    // Byte shifter and modulo byte counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_shift <= '0;
        end else if (clear) begin
            r_count <= '0;
            r_shift <= '0;
        end else if (shift_en) begin
            r_shift <= w_padded;
            r_count <= word_complete ? '0 : (r_count + {{(CW-1){1'b0}}, 1'b1});
        end
    end

    assign word = r_shift;

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Loads a byte stream into instruction memory. Bytes are packed
//            big-endian into words and written one word per write strobe at
//            consecutive byte addresses. Excess bytes beyond 2**N words are
//            discarded and flagged. Holds the CPU via busy while loading.
// Options  : IMEM_LOADER_CHECKSUM_EN adds a running XOR checksum output.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH,
    parameter int N     = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    input  logic             byte_last,
    output logic             byte_ready,
    output logic             we,
    output logic [WIDTH-1:0] waddr,
    output logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
`ifdef IMEM_LOADER_CHECKSUM_EN
    output logic [WIDTH-1:0] checksum,
`endif
    output logic             overflow
);

    state_t     r_state;
    state_t     w_next;
    logic [N:0] r_word_count;
    logic       r_last_seen;
    logic       r_overflow;

    logic       w_full;
    logic       w_accept;
    logic       w_pack_en;
    logic       w_start_ok;
    logic       w_word_complete;

    // Memory is full once the counter's top bit sets (exactly 2**N words).
    assign w_full     = r_word_count[N];
    assign w_accept   = (r_state == COLLECT) && byte_valid;
    assign w_pack_en  = w_accept && !w_full;
    assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));

    imem_word_packer #(
        .WIDTH (WIDTH)
    ) u_packer (
        .clk           (clk),
        .reset_n       (reset_n),
        .clear         (w_start_ok),
        .shift_en      (w_pack_en),
        .byte_last     (byte_last),
        .byte_data     (byte_data),
        .word_complete (w_word_complete),
        .word          (wd)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; once full, bytes are swallowed until the last one.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE, DONE: begin
                if (start) w_next = COLLECT;
            end
            COLLECT: begin
                if (w_accept) begin
                    if (w_full) begin
                        if (byte_last) w_next = DONE;
                    end else if (w_word_complete) begin
                        w_next = WRITE;
                    end
                end
            end
            WRITE: begin
                w_next = r_last_seen ? DONE : COLLECT;
            end
            default: w_next = IDLE;
        endcase
    end

    // Word counter, end-of-image marker and sticky overflow flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_word_count <= '0;
            r_last_seen  <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (w_start_ok) begin
            r_word_count <= '0;
            r_last_seen  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_pack_en && w_word_complete) r_last_seen <= byte_last;
            if (w_accept && w_full)           r_overflow  <= 1'b1;
            if (r_state == WRITE)             r_word_count <= r_word_count + {{N{1'b0}}, 1'b1};
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0] r_checksum;

    // XOR of every word written since the last start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_checksum <= '0;
        end else if (w_start_ok) begin
            r_checksum <= '0;
        end else if (r_state == WRITE) begin
            r_checksum <= r_checksum ^ wd;
        end
    end

    assign checksum = r_checksum;
`endif

    assign byte_ready = (r_state == COLLECT);
    assign we         = (r_state == WRITE);
    assign busy       = (r_state == COLLECT) || (r_state == WRITE);
    assign done       = (r_state == DONE);
    assign overflow   = r_overflow;
    // Counter saturates at 2**N, so the address never wraps back to 0.
    assign waddr      = WIDTH'(r_word_count) << ADDR_SHIFT;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Directed self-checking bench for imem_loader (WIDTH=32, N=2).
//            Define IMEM_LOADER_CHECKSUM_EN to also check the checksum output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int WIDTH = 32;
    localparam int N     = 2;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic        start      = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data  = 8'h00;
    logic        byte_last  = 1'b0;
    logic        byte_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic        overflow;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];

    always #5 clk = ~clk;

    imem_loader #(.WIDTH(WIDTH), .N(N)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .we         (we),
        .waddr      (waddr),
        .wd         (wd),
        .busy       (busy),
        .done       (done),
`ifdef IMEM_LOADER_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .overflow   (overflow)
    );

    // Record every memory write seen on the bus.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            wa_q.push_back(waddr);
            wd_q.push_back(wd);
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        int guard = 0;
        byte_valid = 1'b1; byte_data = b; byte_last = last;
        @(negedge clk);
        while (byte_ready !== 1'b1 && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        if (byte_ready !== 1'b1) begin
            checks++; failures++;
            $display("FAIL send_byte_timeout: byte_ready=%b required 1 for byte %h", byte_ready, b);
        end
        @(posedge clk); #1;
        byte_valid = 1'b0; byte_last = 1'b0;
    endtask

    task automatic wait_done();
        int guard = 0;
        while (done !== 1'b1 && guard < 20) begin
            guard++;
            @(posedge clk); #1;
        end
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL wait_done: done=%b required 1", done); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk); #1;
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL reset_we: got %b want 0", we); end
        checks++; if (waddr !== 32'h0) begin failures++; $display("FAIL reset_waddr: got %h want 0", waddr); end
        checks++; if (wd !== 32'h0) begin failures++; $display("FAIL reset_wd: got %h want 0", wd); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if (byte_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", byte_ready); end
        reset_n = 1'b1;
        // Bytes offered while idle must be ignored.
        byte_valid = 1'b1; byte_data = 8'hFF;
        repeat (3) @(posedge clk); #1;
        byte_valid = 1'b0;
        checks++; if (wa_q.size() != 0) begin failures++; $display("FAIL idle_bytes_ignored: writes=%0d want 0", wa_q.size()); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_two_words();
        wa_q.delete(); wd_q.delete();
        pulse_start();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL two_busy: got %b want 1", busy); end
        send_byte(8'h20, 1'b0); send_byte(8'h08, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h05, 1'b0);
        // One cycle after the completing byte's edge the write must be on the bus.
        checks++; if (we !== 1'b1) begin failures++; $display("FAIL two_latency_we: got %b want 1", we); end
        checks++; if (waddr !== 32'h0) begin failures++; $display("FAIL two_latency_waddr: got %h want 0", waddr); end
        checks++; if (wd !== 32'h20080005) begin failures++; $display("FAIL two_latency_wd: got %h want 20080005", wd); end
        send_byte(8'h8C, 1'b0); send_byte(8'h09, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h04, 1'b1);
        wait_done();
        checks++; if (wa_q.size() != 2) begin failures++; $display("FAIL two_count: writes=%0d want 2", wa_q.size()); end
        else begin
            checks++; if (wa_q[1] !== 32'h4) begin failures++; $display("FAIL two_addr1: got %h want 4", wa_q[1]); end
            checks++; if (wd_q[1] !== 32'h8C090004) begin failures++; $display("FAIL two_data1: got %h want 8C090004", wd_q[1]); end
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL two_busy_end: got %b want 0", busy); end
`ifdef IMEM_LOADER_CHECKSUM_EN
        checks++; if (checksum !== 32'hAC010001) begin failures++; $display("FAIL two_checksum: got %h want AC010001", checksum); end
`endif
    endtask

    task automatic test_partial();
        wa_q.delete(); wd_q.delete();
        pulse_start();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL partial_done_clr: got %b want 0", done); end
        send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b1);
        wait_done();
        checks++; if (wa_q.size() != 1) begin failures++; $display("FAIL partial_count: writes=%0d want 1", wa_q.size()); end
        else begin
            checks++; if (wa_q[0] !== 32'h0) begin failures++; $display("FAIL partial_addr: got %h want 0", wa_q[0]); end
            checks++; if (wd_q[0] !== 32'hAABB0000) begin failures++; $display("FAIL partial_data: got %h want AABB0000", wd_q[0]); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_w;
        wa_q.delete(); wd_q.delete();
        pulse_start();
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
        @(posedge clk); #1;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early: got %b want 0", overflow); end
        send_byte(8'h10, 1'b1);
        wait_done();
        checks++; if (wa_q.size() != 4) begin failures++; $display("FAIL ovf_count: writes=%0d want 4", wa_q.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                exp_w = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
                checks++; if (wa_q[i] !== 32'(4*i)) begin failures++; $display("FAIL ovf_addr%0d: got %h want %h", i, wa_q[i], 32'(4*i)); end
                checks++; if (wd_q[i] !== exp_w) begin failures++; $display("FAIL ovf_data%0d: got %h want %h", i, wd_q[i], exp_w); end
            end
        end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        checks++; if (waddr !== 32'h10) begin failures++; $display("FAIL ovf_nowrap: got %h want 10", waddr); end
    endtask

    task automatic test_start_ignored();
        wa_q.delete(); wd_q.delete();
        pulse_start();
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL restart_ovf_clr: got %b want 0", overflow); end
        send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
        pulse_start();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_start_busy: got %b want 1", busy); end
        send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b0);
        send_byte(8'h05, 1'b0); send_byte(8'h06, 1'b0); send_byte(8'h07, 1'b0); send_byte(8'h08, 1'b1);
        wait_done();
        checks++; if (wa_q.size() != 2) begin failures++; $display("FAIL busy_start_count: writes=%0d want 2", wa_q.size()); end
        else begin
            checks++; if (wd_q[0] !== 32'h01020304) begin failures++; $display("FAIL busy_start_data0: got %h want 01020304", wd_q[0]); end
            checks++; if (wa_q[1] !== 32'h4) begin failures++; $display("FAIL busy_start_addr1: got %h want 4", wa_q[1]); end
            checks++; if (wd_q[1] !== 32'h05060708) begin failures++; $display("FAIL busy_start_data1: got %h want 05060708", wd_q[1]); end
        end
    endtask

    task automatic test_reset_mid();
        wa_q.delete(); wd_q.delete();
        pulse_start();
        send_byte(8'hDE, 1'b0); send_byte(8'hAD, 1'b0); send_byte(8'hBE, 1'b0); send_byte(8'hEF, 1'b0);
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (waddr !== 32'h0) begin failures++; $display("FAIL rstmid_waddr: got %h want 0", waddr); end
        checks++; if (wd !== 32'h0) begin failures++; $display("FAIL rstmid_wd: got %h want 0", wd); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        checks++; if (we !== 1'b0) begin failures++; $display("FAIL rstmid_we: got %b want 0", we); end
        repeat (2) @(posedge clk); #3;
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (wa_q.size() != 1) begin failures++; $display("FAIL rstmid_nowrite: writes=%0d want 1", wa_q.size()); end
        pulse_start();
        send_byte(8'hCA, 1'b0); send_byte(8'hFE, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h0D, 1'b1);
        wait_done();
        checks++; if (wa_q.size() != 2) begin failures++; $display("FAIL rstmid_count: writes=%0d want 2", wa_q.size()); end
        else begin
            checks++; if (wa_q[1] !== 32'h0) begin failures++; $display("FAIL rstmid_addr: got %h want 0", wa_q[1]); end
            checks++; if (wd_q[1] !== 32'hCAFEF00D) begin failures++; $display("FAIL rstmid_data: got %h want CAFEF00D", wd_q[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_partial();
        test_overflow();
        test_start_ignored();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
